// File: rtl/noc_input_buffer.sv
// -----------------------------------------------------------------------------
// noc_input_buffer
//
// Receive side of a router-to-router flit link. Incoming flits are queued in a
// DEPTH-entry FIFO and the head flit is shown to the local switch allocator.
// The allocator sees the flit itself and a one-hot XY route label for it.
// Upstream is held off with `full`. The head is popped when the allocator
// raises `ready`.
//
// Flit layout (DATASIZE = 40):
//   src[39:36] dst[35:32] timestamp[31:24] data[23:2] type[1:0]
//   dst = {dx[1:0], dy[1:0]}
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   data_in    in   flit from the upstream output register
//   data_valid in   data_in holds a valid flit
//   full       out  back-pressure; upstream holds its flit while high
//   ready      in   allocator takes the head flit this cycle
//   label      out  route of the head flit:
//                     1000 W, 0100 N, 0010 E, 0001 S, 0000 local,
//                     1111 when the FIFO is empty
//   data_out   out  head flit, 0 when empty
//   count      out  occupancy, 0..DEPTH
//
// Optional build macro:
//   IBUF_POP_BYPASS_EN
//     When defined, a full buffer that is being popped also accepts a new flit
//     on the same edge, so the one-cycle bubble disappears. The cost is a
//     combinational path from ready to full.
// -----------------------------------------------------------------------------
module noc_input_buffer #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int X_POS    = 0,
    parameter int Y_POS    = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] data_in,
    input  logic                data_valid,
    output logic                full,
    input  logic                ready,
    output logic [3:0]          label,
    output logic [DATASIZE-1:0] data_out,
    output logic [WIDTH:0]      count
);

    localparam logic [WIDTH:0] DEPTH_CNT = (WIDTH+1)'(DEPTH);
    localparam logic [1:0]     X_COORD   = 2'(X_POS);
    localparam logic [1:0]     Y_COORD   = 2'(Y_POS);

    // Bit positions of the destination coordinates inside a flit.
    localparam int DX_HI = DATASIZE - 5;
    localparam int DY_HI = DATASIZE - 7;

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [WIDTH-1:0]    rd_ptr_reg;
    logic [WIDTH-1:0]    wr_ptr_reg;
    logic [WIDTH:0]      count_reg;

    logic                full_int;
    logic                push;
    logic                pop;
    logic                not_empty;
    logic [DATASIZE-1:0] head;
    logic [1:0]          dx;
    logic [1:0]          dy;

    assign not_empty = (count_reg != '0);

`ifdef IBUF_POP_BYPASS_EN
    // A pop frees the slot that the incoming flit lands in on the same edge.
    // When the buffer is full, wr_ptr equals rd_ptr, so that slot is the head.
    // Its old contents are read out before the edge and overwritten at it.
    assign full_int = (count_reg == DEPTH_CNT) & ~ready;
`else
    // Decoded from the registered count only, so ready never reaches full.
    assign full_int = (count_reg == DEPTH_CNT);
`endif

    assign push = data_valid & ~full_int;
    assign pop  = ready & not_empty;

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage has no reset. A write is suppressed while reset is asserted, so
    // a flit offered during reset is dropped rather than left behind as stale.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    // The head is read asynchronously so that a flit pushed into an empty
    // buffer is visible on the very next cycle.
    assign head     = mem[rd_ptr_reg];
    assign data_out = not_empty ? head : '0;
    assign count    = count_reg;
    assign full     = full_int;

    assign dx = head[DX_HI -: 2];
    assign dy = head[DY_HI -: 2];

    // XY dimension-order routing: resolve X first, then Y.
    always_comb begin
        label = 4'b1111;
        if (not_empty) begin
            if (dx > X_COORD) begin
                label = 4'b0010;
            end else if (dx < X_COORD) begin
                label = 4'b1000;
            end else if (dy > Y_COORD) begin
                label = 4'b0001;
            end else if (dy < Y_COORD) begin
                label = 4'b0100;
            end else begin
                label = 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_noc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_noc_input_buffer
//
// Two buffers share one stimulus stream. One sits at router (0,0) and the other
// at router (2,2), so the same flits exercise both routing corners. A queue
// model predicts full/count/data_out/label before every edge.
// -----------------------------------------------------------------------------
module tb_noc_input_buffer;

    localparam int DEPTH = 8;
    localparam int WIDTH = 3;
    localparam int DW    = 40;

`ifdef IBUF_POP_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          ready = 1'b0;

    logic          full0, full1;
    logic [3:0]    label0, label1;
    logic [DW-1:0] data_out0, data_out1;
    logic [WIDTH:0] count0, count1;

    always #5 clk = ~clk;

    noc_input_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DW), .X_POS(0), .Y_POS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .full(full0), .ready(ready), .label(label0), .data_out(data_out0), .count(count0)
    );

    noc_input_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DATASIZE(DW), .X_POS(2), .Y_POS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
        .full(full1), .ready(ready), .label(label1), .data_out(data_out1), .count(count1)
    );

    int            vec_count   = 0;
    int            miscompares = 0;
    logic [DW-1:0] q[$];
    bit            last_push;
    bit            verbose = 1'b1;

    typedef struct {
        logic [3:0] dst;
        logic [3:0] lbl00;   // label expected at router (0,0)
        logic [3:0] lbl22;   // label expected at router (2,2)
    } route_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Route derived directly from the XY dimension-order rule.
    function automatic logic [3:0] route(input logic [DW-1:0] f, input int xp, input int yp);
        int dx;
        int dy;
        dx = int'(f[35:34]);
        dy = int'(f[33:32]);
        if (dx > xp) return 4'b0010;
        if (dx < xp) return 4'b1000;
        if (dy > yp) return 4'b0001;
        if (dy < yp) return 4'b0100;
        return 4'b0000;
    endfunction

    function automatic logic [DW-1:0] mkflit(input logic [3:0] dst, input int val);
        logic [21:0] d;
        d = 22'(val);
        return {4'h5, dst, 8'h00, d, 2'b01};
    endfunction

    // Compare every output with the model, advance one clock, then update the
    // model with whatever push/pop the rules allow on that edge.
    task automatic cyc();
        bit            exp_full;
        bit            do_push;
        bit            do_pop;
        logic [DW-1:0] exp_data;
        logic [3:0]    exp_l0;
        logic [3:0]    exp_l1;
        #1;
        exp_full = (q.size() == DEPTH) && !(BYPASS && ready);
        exp_data = (q.size() == 0) ? '0 : q[0];
        exp_l0   = (q.size() == 0) ? 4'hF : route(q[0], 0, 0);
        exp_l1   = (q.size() == 0) ? 4'hF : route(q[0], 2, 2);
        check("full0",  64'(full0),     64'(exp_full));
        check("full1",  64'(full1),     64'(exp_full));
        check("count0", 64'(count0),    64'(q.size()));
        check("count1", 64'(count1),    64'(q.size()));
        check("data0",  64'(data_out0), 64'(exp_data));
        check("data1",  64'(data_out1), 64'(exp_data));
        check("label0", 64'(label0),    64'(exp_l0));
        check("label1", 64'(label1),    64'(exp_l1));
        do_push = data_valid && !exp_full;
        do_pop  = ready && (q.size() != 0);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            last_push = 1'b0;
            if (verbose) $display("t=%0t reset", $time);
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(data_in);
            last_push = do_push;
            if (verbose && (do_push || do_pop))
                $display("t=%0t push=%0d pop=%0d flit=%h occ=%0d", $time, do_push, do_pop, data_in, q.size());
        end
        #1;
    endtask

    initial begin
        route_vec_t tbl[8];
        logic [DW-1:0] f1, f2, f3, fx;
        logic [63:0]   r;
        int            acc9;

        tbl[0] = '{4'b1001, 4'b0010, 4'b0100};
        tbl[1] = '{4'b0011, 4'b0001, 4'b1000};
        tbl[2] = '{4'b0000, 4'b0000, 4'b1000};
        tbl[3] = '{4'b0110, 4'b0010, 4'b1000};
        tbl[4] = '{4'b1010, 4'b0010, 4'b0000};
        tbl[5] = '{4'b1011, 4'b0010, 4'b0001};
        tbl[6] = '{4'b1100, 4'b0010, 4'b0010};
        tbl[7] = '{4'b0001, 4'b0001, 4'b1000};

        // Reset, then idle.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        rst_n = 1'b1;
        #1;
        check("rst_label0", 64'(label0), 64'(4'hF));
        check("rst_label1", 64'(label1), 64'(4'hF));
        check("rst_data0", 64'(data_out0), 64'd0);
        check("rst_count0", 64'(count0), 64'd0);
        check("rst_full0", 64'(full0), 64'd0);

        // Ready on an empty buffer does nothing.
        ready = 1'b1;
        repeat (3) cyc();
        check("idle_ready_count", 64'(count0), 64'd0);
        ready = 1'b0;

        // Table of single-flit route vectors at both router positions.
        for (int i = 0; i < 8; i++) begin
            data_in    = mkflit(tbl[i].dst, i + 1);
            data_valid = 1'b1;
            cyc();
            data_valid = 1'b0;
            #1;
            check("tbl_label00", 64'(label0), 64'(tbl[i].lbl00));
            check("tbl_label22", 64'(label1), 64'(tbl[i].lbl22));
            check("tbl_data", 64'(data_out0), 64'(data_in));
            ready = 1'b1;
            cyc();
            ready = 1'b0;
            check("tbl_drain", 64'(count0), 64'd0);
        end

        // Three flits streamed through with ready held high.
        f1 = mkflit(4'b1001, 11);
        f2 = mkflit(4'b0011, 12);
        f3 = mkflit(4'b0000, 13);
        ready = 1'b1;
        data_valid = 1'b1;
        data_in = f1; cyc();
        check("seq_l1", 64'(label0), 64'(4'b0010));
        check("seq_d1", 64'(data_out0), 64'(f1));
        data_in = f2; cyc();
        check("seq_l2", 64'(label0), 64'(4'b0001));
        check("seq_d2", 64'(data_out0), 64'(f2));
        data_in = f3; cyc();
        check("seq_l3", 64'(label0), 64'(4'b0000));
        check("seq_d3", 64'(data_out0), 64'(f3));
        data_valid = 1'b0;
        cyc();
        check("seq_empty", 64'(count0), 64'd0);
        ready = 1'b0;

        // Router (2,2): west first, then north after the pop.
        data_valid = 1'b1;
        data_in = mkflit(4'b0110, 21); cyc();
        data_in = mkflit(4'b1001, 22); cyc();
        data_valid = 1'b0;
        #1;
        check("r22_west", 64'(label1), 64'(4'b1000));
        ready = 1'b1; cyc(); ready = 1'b0;
        check("r22_north", 64'(label1), 64'(4'b0100));
        ready = 1'b1; cyc(); ready = 1'b0;

        // Fill to the brim, hold a ninth flit, then release.
        data_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_in = mkflit(4'b0000, i);
            cyc();
            check("fill_count", 64'(count0), 64'(i));
        end
        check("fill_full", 64'(full0), 64'd1);
        data_in = mkflit(4'b0000, 9);
        repeat (3) cyc();
        check("hold_count", 64'(count0), 64'd8);
        ready = 1'b1;
        #1;
        check("release_full", 64'(full0), 64'(!BYPASS));
        cyc();
        check("bubble_push", 64'(last_push), 64'(BYPASS));
        check("bubble_count", 64'(count0), BYPASS ? 64'd8 : 64'd7);
        acc9 = last_push ? 1 : 0;
        if (last_push) data_valid = 1'b0;
        for (int k = 0; k < 11; k++) begin
            cyc();
            if (last_push) begin
                acc9++;
                data_valid = 1'b0;
            end
        end
        check("flit9_once", 64'(acc9), 64'd1);
        check("drain_count", 64'(count0), 64'd0);
        ready = 1'b0;

        // Continuous push and pop across several pointer wraps.
        ready = 1'b1;
        data_valid = 1'b1;
        data_in = mkflit(4'b0100, 100);
        cyc();
        for (int k = 1; k < 20; k++) begin
            data_in = mkflit(4'b0100, 100 + k);
            cyc();
            check("stream_count", 64'(count0), 64'd1);
        end
        data_valid = 1'b0;
        cyc();
        check("stream_drain", 64'(count0), 64'd0);
        ready = 1'b0;

        // Reset with five flits buffered; the concurrent push/pop is dropped.
        data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = mkflit(4'b0001, 200 + i);
            cyc();
        end
        check("pre_rst_count", 64'(count0), 64'd5);
        rst_n = 1'b0;
        ready = 1'b1;
        data_in = mkflit(4'b1111, 77);
        cyc();
        rst_n = 1'b1;
        ready = 1'b0;
        data_valid = 1'b0;
        check("mid_rst_count", 64'(count0), 64'd0);
        check("mid_rst_label", 64'(label0), 64'(4'hF));
        fx = mkflit(4'b1110, 300);
        data_in = fx;
        data_valid = 1'b1;
        cyc();
        data_valid = 1'b0;
        check("post_rst_head", 64'(data_out0), 64'(fx));
        check("post_rst_count", 64'(count0), 64'd1);
        ready = 1'b1; cyc(); ready = 1'b0;

        // Randomised traffic, alternating between filling and draining phases.
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r = {$urandom(), $urandom()};
            data_in    = r[DW-1:0];
            rst_n      = ($urandom_range(199) != 0);
            data_valid = ($urandom_range(9) < 6);
            if (((i / 300) % 2) == 0)
                ready = ($urandom_range(9) < 3);
            else
                ready = ($urandom_range(9) < 8);
            cyc();
        end
        rst_n = 1'b1;
        data_valid = 1'b0;
        ready = 1'b0;
        $display("random phase complete, final occupancy %0d", q.size());

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/noc_input_buffer.md
Name: noc_input_buffer

Overview:
- Receive end of the router-to-router flit link: accepts flits from an upstream output stage, buffers them in a FIFO, and returns a full back-pressure signal.
- Computes the XY route of the head flit and presents it as a one-hot 4-bit label plus head data to the local switch allocator.
- Pops the head flit when the allocator asserts ready.
- One instance per router input port (L, N, E, S, W).

Parameters:
- DEPTH, 8, FIFO entries; must equal 2**WIDTH.
- WIDTH, 3, pointer width.
- DATASIZE, 40, flit width: src[39:36], dst[35:32], timestamp[31:24], data[23:2], type[1:0].
- X_POS, 0, 2-bit x coordinate of this router.
- Y_POS, 0, 2-bit y coordinate of this router.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- data_in  input  DATASIZE  flit from upstream output register.
- data_valid  input  1  data_in holds a valid flit.
- full  output  1  back-pressure to upstream; upstream holds data_in/data_valid while high.
- ready  input  1  allocator accepts the head flit this cycle.
- label  output  4  route of head flit: 1000 W, 0100 N, 0010 E, 0001 S, 0000 local, 1111 empty/invalid.
- data_out  output  DATASIZE  head flit.
- count  output  WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: when rst_n=0 at a clock edge:
  - rd_ptr, wr_ptr and count go to 0; full=0; label=1111; data_out=0.
  - Memory contents are not cleared.
  - A push or pop in the same cycle is discarded, including reset asserted mid-stream.
- push = data_valid & ~full. On push, data_in is written at wr_ptr and wr_ptr increments modulo DEPTH (natural wrap).
- pop = ready & (count!=0). On pop, rd_ptr increments modulo DEPTH. ready while empty is ignored.
- count update:
  - +1 on push only; -1 on pop only; unchanged on simultaneous push and pop.
  - Never exceeds DEPTH; never underflows.
- full = (count==DEPTH), decoded from registered count (no combinational path from ready), except as described under Optional Feature.
- Hold protocol: upstream keeps the same flit while full=1. The edge where full is low is the single acceptance edge, so each flit is written exactly once.
- Output latency:
  - data_out = mem[rd_ptr] when count!=0, else 0.
  - The first flit into an empty FIFO appears on data_out/label the cycle after its push edge; there is no write-through.
- Route, combinational on the head flit, with dx=dst[35:34], dy=dst[33:32]:
  - dx>X_POS gives E; dx<X_POS gives W.
  - Else dy>Y_POS gives S; dy<Y_POS gives N.
  - Else local (0000).
  - Empty gives 1111.
- Full and pop in the same cycle: pop occurs and count becomes DEPTH-1. The upstream flit is taken on the next edge (one-cycle bubble).
- Flits leave in arrival order; no reordering or drop.

Optional Feature:
- Macro IBUF_POP_BYPASS_EN.
- Defined:
  - full = (count==DEPTH) & ~(ready).
  - When full, a simultaneous pop and push are both allowed at one edge, with count held at DEPTH.
  - This removes the bubble at the cost of a ready-to-full combinational path.
- Undefined: full = (count==DEPTH) exactly as in Behaviour.

Test Plan:
- Reset then idle: label=1111, data_out=0, count=0, full=0. Assert ready with no data: count stays 0, no pointer change.
- X_POS=0, Y_POS=0. Push dst=1001 (x2,y1), then dst=0011 (x0,y3), then dst=0000, ready=1:
  - label sequence 0010, 0001, 0000 on consecutive cycles, data_out matching each flit;
  - count returns to 0.
- X_POS=2, Y_POS=2. Push dst=0110 (x1,y2), then dst=1001 (x2,y1): label 1000, then 0100 after pop.
- ready=0, push 8 flits (data=1..8): full=1 after the 8th edge, count=8. Hold a 9th flit with valid=1 for 3 cycles: count stays 8. Raise ready: pops 1..8 in order, flit 9 is accepted exactly once, with one bubble (macro off) or none (macro on).
- Continuous push+pop for 20 flits across pointer wrap: order preserved, count constant at 1.
- rst_n=0 for one edge with count=5: count=0, label=1111 next cycle. A flit pushed the following cycle is the next head.
